// File: rtl/siso_shift_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : siso_shift_controller                                       |
// | Purpose  : Sequences a DEPTH-stage serial-in/serial-out shift chain.   |
// |            A parallel word taken over the load handshake is streamed  |
// |            LSB-first into the chain, followed by DEPTH zero bits that  |
// |            flush it. The bits coming out of the chain are collected   |
// |            back into a parallel word and returned over the rx          |
// |            handshake.                                                 |
// | Ports    : clk1, rst1        clock / async active-high reset          |
// |            load_valid/ready  parallel word handshake (load_data)      |
// |            sr_in, sr_shift   serial data and shift enable to chain    |
// |            sr_out            serial data from the last chain stage    |
// |            rx_valid/ready    captured word handshake (rx_data)        |
// |            busy              transaction in progress                  |
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module siso_shift_controller #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk1,
  input  logic             rst1,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sr_in,
  output logic             sr_shift,
  input  logic             sr_out,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CW-1:0] C_LAST  = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] tx_q,    tx_d;
  logic [WIDTH-1:0] rx_q,    rx_d;
  logic [WIDTH-1:0] tx_shifted;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_valid)       state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == C_LAST)  state_d = ST_DONE;
      ST_DONE:  if (rx_ready)         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from state and registered datapath only, so neither
  // handshake input has a combinational path to any output.
  // ---------------------------------------------------------------------
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    sr_shift   = 1'b0;
    rx_valid   = 1'b0;
    sr_in      = 1'b0;
    tx_shifted = tx_q >> cnt_q;
    case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        sr_shift = 1'b1;
        // Past the last data bit the chain is flushed with zeros.
        sr_in    = (cnt_q < C_WIDTH) ? tx_shifted[0] : 1'b0;
      end
      ST_DONE: begin
        busy     = 1'b1;
        rx_valid = 1'b1;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
    rx_data = rx_q;
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    tx_d  = tx_q;
    rx_d  = rx_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          tx_d  = load_data;
          cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        // The first DEPTH bits leaving the chain predate this transaction;
        // bit i of the word emerges DEPTH cycles after it was inserted.
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CW'(i + DEPTH)) begin
            rx_d[i] = sr_out;
          end
        end
        if (cnt_q == C_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      cnt_q <= '0;
      tx_q  <= '0;
      rx_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_siso_shift_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_siso_shift_controller                                    |
// | Purpose  : Self-checking bench for siso_shift_controller with ideal    |
// |            4-stage chains attached to a 4/4 and an 8/4 instance.       |
// | Revision : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module tb_siso_shift_controller;

  logic clk1 = 1'b0;
  logic rst1 = 1'b1;
  always #5 clk1 = ~clk1;

  // 4/4 instance
  logic       load_valid = 1'b0, load_ready, sr_in, sr_shift, sr_out;
  logic       rx_valid, rx_ready = 1'b0, busy;
  logic [3:0] load_data = 4'h0, rx_data;

  // 8/4 instance
  logic       load_valid8 = 1'b0, load_ready8, sr_in8, sr_shift8, sr_out8;
  logic       rx_valid8, rx_ready8 = 1'b0, busy8;
  logic [7:0] load_data8 = 8'h0, rx_data8;

  siso_shift_controller #(.WIDTH(4), .DEPTH(4)) u_dut (
    .clk1(clk1), .rst1(rst1),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .sr_in(sr_in), .sr_shift(sr_shift), .sr_out(sr_out),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .busy(busy)
  );

  siso_shift_controller #(.WIDTH(8), .DEPTH(4)) u_dut8 (
    .clk1(clk1), .rst1(rst1),
    .load_valid(load_valid8), .load_ready(load_ready8), .load_data(load_data8),
    .sr_in(sr_in8), .sr_shift(sr_shift8), .sr_out(sr_out8),
    .rx_valid(rx_valid8), .rx_ready(rx_ready8), .rx_data(rx_data8),
    .busy(busy8)
  );

  // Ideal 4-stage chains; reset does not touch them.
  logic [3:0] chain = 4'h0, chain8 = 4'h0;
  logic       preload_en = 1'b0;
  logic [3:0] preload_val = 4'h0;
  always @(posedge clk1) begin
    if (preload_en)    chain <= preload_val;
    else if (sr_shift) chain <= {chain[2:0], sr_in};
    if (sr_shift8)     chain8 <= {chain8[2:0], sr_in8};
  end
  assign sr_out  = chain[3];
  assign sr_out8 = chain8[3];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // rx_valid monitor used by the back-to-back scenario
  int         cyc = 0;
  logic       mon_en = 1'b0;
  int         pulse_cyc[$];
  logic [3:0] pulse_dat[$];
  always @(negedge clk1) begin
    cyc++;
    if (mon_en && rx_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(rx_data);
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of SHIFT cycle 1.
  task automatic accept(input logic [3:0] word);
    check_eq("load_ready_idle", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = word;
    @(negedge clk1);
    load_valid = 1'b0;
    load_data  = 4'($urandom);
  endtask

  // From SHIFT cycle 1: word bits LSB-first, then 4 zeros; then DONE.
  task automatic shift_and_check(input logic [3:0] word);
    logic exp_bit;
    for (int i = 0; i < 8; i++) begin
      exp_bit = (i < 4) ? word[i] : 1'b0;
      check_eq("sr_shift_on", sr_shift, 1'b1);
      check_eq("busy_shift", busy, 1'b1);
      check_eq("load_ready_shift", load_ready, 1'b0);
      check_eq("rx_valid_shift", rx_valid, 1'b0);
      check_eq($sformatf("sr_in[%0d]", i), sr_in, exp_bit);
      @(negedge clk1);
    end
    check_eq("rx_valid_done", rx_valid, 1'b1);
    check_eq("sr_shift_done", sr_shift, 1'b0);
    check_eq("busy_done", busy, 1'b1);
    check_eq("rx_data", rx_data, word);
  endtask

  task automatic release_rx;
    rx_ready = 1'b1;
    @(negedge clk1);
    check_eq("rx_valid_after_hs", rx_valid, 1'b0);
    check_eq("load_ready_after_hs", load_ready, 1'b1);
    check_eq("busy_after_hs", busy, 1'b0);
    rx_ready = 1'b0;
  endtask

  task automatic run8(input logic [7:0] word);
    int n_shift;
    int c;
    check_eq("load_ready8", load_ready8, 1'b1);
    load_valid8 = 1'b1;
    load_data8  = word;
    @(negedge clk1);
    load_valid8 = 1'b0;
    load_data8  = 8'($urandom);
    n_shift = 0;
    c = 1;
    while (!rx_valid8 && c < 40) begin
      if (sr_shift8) n_shift++;
      @(negedge clk1);
      c++;
    end
    check_eq("shift_count8", n_shift, 12);
    check_eq("rx_valid_cycle8", c, 13);
    check_eq("rx_data8", rx_data8, word);
    rx_ready8 = 1'b1;
    @(negedge clk1);
    check_eq("rx_valid8_after_hs", rx_valid8, 1'b0);
    rx_ready8 = 1'b0;
  endtask

  initial begin
    logic [3:0] w;
    logic [3:0] bb [3];
    int d;
    bb[0] = 4'h3; bb[1] = 4'hC; bb[2] = 4'h9;

    // Reset state
    repeat (2) @(negedge clk1);
    check_eq("rst_load_ready", load_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_sr_shift", sr_shift, 1'b0);
    check_eq("rst_sr_in", sr_in, 1'b0);
    check_eq("rst_rx_data", rx_data, 4'h0);
    rst1 = 1'b0;
    @(negedge clk1);

    // Basic transaction
    accept(4'b1011);
    shift_and_check(4'b1011);
    release_rx();

    // Stale chain contents are never captured
    preload_en  = 1'b1;
    preload_val = 4'hF;
    @(negedge clk1);
    preload_en = 1'b0;
    accept(4'b0000);
    shift_and_check(4'b0000);
    release_rx();
    accept(4'b1000);
    shift_and_check(4'b1000);
    release_rx();

    // Consumer stalls with a new word already offered
    accept(4'b1011);
    shift_and_check(4'b1011);
    load_valid = 1'b1;
    load_data  = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1);
      check_eq("hold_rx_valid", rx_valid, 1'b1);
      check_eq("hold_rx_data", rx_data, 4'b1011);
      check_eq("hold_sr_shift", sr_shift, 1'b0);
      check_eq("hold_load_ready", load_ready, 1'b0);
    end
    rx_ready = 1'b1;
    @(negedge clk1);
    rx_ready = 1'b0;
    check_eq("gap_load_ready", load_ready, 1'b1);
    check_eq("gap_busy", busy, 1'b0);
    @(negedge clk1);
    load_valid = 1'b0;
    load_data  = 4'h0;
    shift_and_check(4'b0110);
    release_rx();

    // Asynchronous reset in the middle of SHIFT
    accept(4'b1011);
    repeat (3) @(negedge clk1);
    check_eq("pre_rst_sr_shift", sr_shift, 1'b1);
    #2 rst1 = 1'b1;
    #1;
    check_eq("arst_sr_shift", sr_shift, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_rx_valid", rx_valid, 1'b0);
    check_eq("arst_rx_data", rx_data, 4'h0);
    check_eq("arst_load_ready", load_ready, 1'b1);
    #1 rst1 = 1'b0;
    @(negedge clk1);
    accept(4'b0101);
    shift_and_check(4'b0101);
    release_rx();

    // Random words with random consumer stalls
    for (int k = 0; k < 16; k++) begin
      w = 4'($urandom);
      d = $urandom_range(0, 3);
      accept(w);
      shift_and_check(w);
      for (int j = 0; j < d; j++) begin
        @(negedge clk1);
        check_eq("rand_hold_valid", rx_valid, 1'b1);
        check_eq("rand_hold_data", rx_data, w);
      end
      release_rx();
    end

    // Back-to-back with both handshakes held high
    mon_en     = 1'b1;
    rx_ready   = 1'b1;
    load_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load_data = bb[k];
      repeat (10) @(negedge clk1);
    end
    load_valid = 1'b0;
    repeat (3) @(negedge clk1);
    mon_en   = 1'b0;
    rx_ready = 1'b0;
    check_eq("b2b_pulses", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) check_eq("b2b_data", pulse_dat[k], bb[k]);
      check_eq("b2b_gap0", pulse_cyc[1] - pulse_cyc[0], 10);
      check_eq("b2b_gap1", pulse_cyc[2] - pulse_cyc[1], 10);
    end

    // WIDTH=8 instance
    run8(8'hA5);
    for (int k = 0; k < 3; k++) run8(8'($urandom));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
